// File: rtl/board_ram_arbiter_if.sv
// board_ram_arbiter_if: game-logic request/response bus into the board RAM arbiter.
//   game_req/game_we/game_addr/game_wdata : requester -> arbiter, held until game_ack
//   game_ack                              : arbiter -> requester, access issued this cycle
//   game_rvalid/game_rdata                : arbiter -> requester, read return pulse and data
interface board_ram_arbiter_if #(
    parameter int CELL_BITS = 4
);
    logic                 game_req;
    logic                 game_we;
    logic [8:0]           game_addr;
    logic [CELL_BITS-1:0] game_wdata;
    logic                 game_ack;
    logic                 game_rvalid;
    logic [CELL_BITS-1:0] game_rdata;

    modport master (
        output game_req, game_we, game_addr, game_wdata,
        input  game_ack, game_rvalid, game_rdata
    );

    modport slave (
        input  game_req, game_we, game_addr, game_wdata,
        output game_ack, game_rvalid, game_rdata
    );
endinterface

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the single-port board RAM between VGA prefetch, bulk clear and game logic.
//   clk, rst                    : pixel clock, synchronous active-high reset
//   video_x, video_y, video_cell: scan position in, cell code under the beam out
//   game                        : game-logic request/response bus (slave side)
//   clear_start, busy, clear_done: bulk clear control and status
//   ram_addr, ram_we, ram_wdata, ram_rdata: single-port RAM, one-cycle read latency
module board_ram_arbiter #(
    parameter int                   COLS        = 20,
    parameter int                   ROWS        = 15,
    parameter int                   CELL_BITS   = 4,
    parameter logic [CELL_BITS-1:0] CLEAR_VALUE = 4'hA,
    parameter int                   H_ACTIVE    = 640,
    parameter int                   H_TOTAL     = 800,
    parameter int                   V_ACTIVE    = 480,
    parameter int                   V_TOTAL     = 525
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           video_x,
    input  logic [9:0]           video_y,
    output logic [CELL_BITS-1:0] video_cell,
    board_ram_arbiter_if.slave   game,
    input  logic                 clear_start,
    output logic                 busy,
    output logic                 clear_done,
    output logic [8:0]           ram_addr,
    output logic                 ram_we,
    output logic [CELL_BITS-1:0] ram_wdata,
    input  logic [CELL_BITS-1:0] ram_rdata
);
    localparam int         CELLS  = COLS * ROWS;
    localparam logic [8:0] COLS9  = 9'(COLS);
    localparam logic [8:0] CELLS9 = 9'(CELLS);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state, state_next;
    logic [8:0]           cnt, cnt_next;
    logic                 clear_done_next;
    logic [9:0]           ny;
    logic                 mid_slot, sol_slot, video_slot, clear_wr;
    logic [8:0]           video_addr;
    logic                 slot_d, pf_ok, rd_d1, oob_d1;
    logic [CELL_BITS-1:0] pf;

    // Mid-line slots fetch the next column of the current row; the slot at x=796
    // fetches column 0 of the following line so it is ready at x=0.
    assign ny         = (video_y == 10'(V_TOTAL - 1)) ? '0 : video_y + 10'd1;
    assign mid_slot   = video_x < 10'(H_ACTIVE) && video_y < 10'(V_ACTIVE) && video_x[4:0] == 5'd28
                        && {1'b0, video_x[9:5]} + 6'd1 < 6'(COLS);
    assign sol_slot   = video_x == 10'(H_TOTAL - 4) && ny < 10'(V_ACTIVE);
    assign video_slot = !rst && (mid_slot || sol_slot);
    assign video_addr = mid_slot ? {4'b0, video_y[9:5]} * COLS9 + {4'b0, video_x[9:5]} + 9'd1
                                 : {4'b0, ny[9:5]} * COLS9;

    assign busy          = state == CLEAR;
    assign clear_wr      = !rst && state == CLEAR && !video_slot;
    assign game.game_ack = !rst && game.game_req && state == IDLE && !clear_start && !video_slot;

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        clear_done_next = 1'b0;
        if (state == IDLE && clear_start) begin
            state_next = CLEAR;
            cnt_next   = '0;
        end
        if (clear_wr) begin
            cnt_next = cnt + 9'd1;
            if (cnt == CELLS9 - 9'd1) begin
                state_next      = IDLE;
                clear_done_next = 1'b1;
            end
        end
        ram_addr  = video_slot ? video_addr : clear_wr ? cnt : game.game_ack ? game.game_addr : '0;
        ram_we    = clear_wr || (game.game_ack && game.game_we && game.game_addr < CELLS9);
        ram_wdata = clear_wr ? CLEAR_VALUE : game.game_ack ? game.game_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            clear_done       <= 1'b0;
            slot_d           <= 1'b0;
            pf               <= '0;
            pf_ok            <= 1'b0;
            video_cell       <= '0;
            rd_d1            <= 1'b0;
            oob_d1           <= 1'b0;
            game.game_rvalid <= 1'b0;
            game.game_rdata  <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            clear_done <= clear_done_next;
            slot_d     <= video_slot;
            // Hand the prefetched code to the renderer on the last pixel of the current cell.
            if (video_x[4:0] == 5'd31 && pf_ok) begin
                video_cell <= pf;
                pf_ok      <= 1'b0;
            end
            if (slot_d) begin
                pf    <= ram_rdata;
                pf_ok <= 1'b1;
            end
            rd_d1            <= game.game_ack && !game.game_we;
            oob_d1           <= game.game_addr >= CELLS9;
            game.game_rvalid <= rd_d1;
            if (rd_d1)
                game.game_rdata <= oob_d1 ? '0 : ram_rdata;
        end
    end
endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview:
- Shares the single-port minesweeper board RAM (20x15 cells of 32x32 px, 4-bit cell code each) between three users.
- Users, in priority order: the VGA scan path (prefetches the cell code for the next 32-px column), a bulk-clear sequencer, and the game-logic requester.
- Sits between the 640x480 timing generator (pixel x/y counters) and the tile renderer, which uses video_cell to select the tile bitmap.

Parameters:
- COLS, 20, board columns (640/32)
- ROWS, 15, board rows (480/32)
- CELL_BITS, 4, width of one cell code
- CLEAR_VALUE, 4'hA, code written to every cell by a bulk clear ("covered")
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixels per line including blanking
- V_ACTIVE, 480, active lines
- V_TOTAL, 525, lines per frame including blanking

Ports:
- clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- video_x  in  10  current pixel column from the timing generator, 0..799
- video_y  in  10  current line from the timing generator, 0..524
- video_cell  out  CELL_BITS  cell code for the 32-px cell under video_x/video_y
- game_req  in  1  game access request; held until acked
- game_we  in  1  1 = write, 0 = read
- game_addr  in  9  cell index, row*COLS+col
- game_wdata  in  CELL_BITS  write data
- game_ack  out  1  combinational; access issued this cycle
- game_rvalid  out  1  one-cycle pulse; game_rdata is valid
- game_rdata  out  CELL_BITS  read data
- clear_start  in  1  one-cycle pulse; start a bulk clear
- busy  out  1  high while a clear is in progress
- clear_done  out  1  one-cycle pulse after the last clear write
- ram_addr  out  9  RAM address (combinational)
- ram_we  out  1  RAM write enable (combinational)
- ram_wdata  out  CELL_BITS  RAM write data
- ram_rdata  in  CELL_BITS  RAM read data, valid the cycle after the address is issued

Behaviour:
- Reset values: video_cell=0, game_ack=0, game_rvalid=0, game_rdata=0, busy=0, clear_done=0, ram_we=0, ram_addr=0; state goes to IDLE.
- Video slot (absolute priority, ram_we=0) occurs in either case:
  - Mid-line prefetch: video_x<640, video_y<480, video_x[4:0]==28, and (video_x>>5)+1<COLS. Address = (video_y>>5)*COLS + (video_x>>5)+1.
  - Start-of-line prefetch: video_x==796 and ny<480, where ny = (video_y==524) ? 0 : video_y+1. Address = (ny>>5)*COLS.
- Video data path:
  - ram_rdata is captured into the prefetch register at the end of the cycle following a video slot.
  - video_cell loads from the prefetch register at the end of any cycle with video_x[4:0]==31 that followed a video slot, so it is valid across x[4:0]=0..31 of the target cell.
  - No video slot for column 20 and none during vertical blanking; video_cell holds its value.
- FSM states:
  - IDLE: clear_start moves to CLEAR, clears the counter to 0, sets busy=1. No game ack in that cycle.
  - CLEAR: in each non-video cycle, write CLEAR_VALUE to the counter address and increment. After writing address COLS*ROWS-1 (299), return to IDLE with busy=0 and pulse clear_done for one cycle. clear_start is ignored while in CLEAR.
- Game access:
  - game_ack = game_req && state==IDLE && !clear_start && !video_slot.
  - Unacked requests stay pending; the requester holds all inputs stable.
  - Maximum wait in IDLE is 1 cycle, or the rest of the clear when one is in progress.
  - Write: RAM written in the ack cycle. game_addr>=300 suppresses ram_we but is still acked.
  - Read (ack in cycle N): game_rdata is registered at the end of N+1 and game_rvalid is high in N+2. game_addr>=300 returns 0.
- Back-to-back game acks are allowed every cycle; the read return pipeline is 2 deep.
- rst during CLEAR aborts to IDLE: no clear_done pulse, board contents are partially cleared.

Test Plan:
1. Video prefetch: preload cell 21 (row 1, col 1) = 4'h3, sweep video_y=32 with video_x 28..32 -> ram_addr=21 at x=28 with ram_we=0; video_cell=3 from x=32.
2. Line wrap: video_y=524, video_x=796 -> ram_addr=0; video_y=479, video_x=796 -> no slot, ram_we=0 and no RAM access.
3. Collision: hold a game_req write to addr 5 with video_x[4:0]=28 in the active area -> game_ack=0 at x=28, game_ack=1 at x=29, cell 5 updated, and the video prefetch is unaffected.
4. Game read: with cell 7=4'h8, read addr 7 acked in cycle N -> game_rvalid=1 with game_rdata=8 in cycle N+2. Read addr 310 -> game_rdata=0.
5. Bulk clear during the active frame: clear_start -> busy=1, exactly 300 writes of 4'hA that skip video slots, then one clear_done pulse. A game_req held throughout is acked only after busy falls, and all cells read 4'hA.
6. Reset mid-clear after 100 writes -> busy=0 the next cycle, no clear_done pulse, cells 0..99=4'hA, and a new clear_start is accepted.
